timer_multi: RTL
================

// Module: timer_multi
// PURPOSE
//  Parametrised N-channel successor to the single-channel peripheral timer. Each channel has its own
//  compare value, one-shot or periodic (auto-reload) mode, interrupt enable and W1C pending flag.
//  Sits on the peripheral bus next to the other memory-mapped slaves. The merged interrupt feeds the core.
// PARAMETERS
//  NUM_CH   4   number of timer channels, 1..15
//  CNT_W    32  counter/compare width, 8..32; registers are zero-extended to 32 b on read
//  PSC_W    8   prescaler width; used only when TIMER_PRESCALER_EN is defined
// PORTS
//  clk           in   1        system clock
//  rst           in   1        asynchronous, active-high reset
//  we_i          in   1        write enable (`WriteEnable)
//  addr_i        in   32       byte address; [7:4] = channel index, [3:0] = register offset
//  wdata_i       in   32       write data
//  rdata_o       out  32       read data, combinational from addr_i
//  int_ch_o      out  NUM_CH   per-channel interrupt: pending & int_en
//  int_signal_o  out  32       `TIME_INT if any int_ch_o bit is set, else `INT_NONE
// BEHAVIOUR
//  Map per channel c (c < NUM_CH), base c*16:
//   +0 CTRL  - [0] en, [1] int_en, [2] pending (W1C), [3] mode (0 one-shot, 1 periodic), [15:8] psc; other bits read 0
//   +4 VALUE - compare value (CNT_W bits)
//   +8 CNT   - current count, read-only
//   0xF0 INT_STATUS - pending bits [NUM_CH-1:0]; write 1 clears that bit
//   Unmapped read returns `ZeroWord. Unmapped write, or a write to CNT, is ignored.
//  Reset: every CTRL, VALUE and CNT = 0; rdata_o follows addr_i; int_ch_o = 0; int_signal_o = `INT_NONE.
//  Tick: with en = 1, a tick occurs every cycle, or every psc+1 cycles with the prescaler.
//   With en = 0 there are no ticks, CNT holds, and the prescaler counter is cleared.
//  On each tick:
//   - cnt == VALUE-1: cnt <= 0 and pending <= 1. In one-shot mode, en <= 0 in the same cycle.
//   - otherwise: cnt <= cnt+1.
//   - Period is VALUE ticks. VALUE == 0: the channel never fires and cnt stays 0.
//  Register writes take effect at the clock edge:
//   - Writing VALUE clears cnt and the prescaler counter.
//   - Writing CTRL with en 1->0 clears cnt.
//   - Writing CTRL with en 0->1 starts counting from the current cnt.
//  Simultaneous events:
//   - Hardware pending-set in the same cycle as a software W1C: set wins (no lost interrupt).
//   - Hardware en-clear (one-shot expiry) in the same cycle as a CTRL write: the CTRL write wins for en,
//     and the set rule above still applies to pending.
//  Wrap-around: cnt never exceeds VALUE-1. If VALUE is written below cnt, cnt is cleared, so there is no
//   2^CNT_W run-on.
//  Interrupt latency: pending is visible on int_ch_o in the cycle after the terminal-tick edge.
//   int_signal_o is combinational from int_ch_o.
//  Asserting rst mid-count returns every channel to its reset state immediately.
// CONFIGURATION
//  TIMER_PRESCALER_EN defined:
//   - Each channel has a PSC_W-bit prescaler driven by CTRL[15:8].
//   - CTRL[15:8] is read/write.
//  TIMER_PRESCALER_EN undefined:
//   - Tick = every cycle while en = 1.
//   - CTRL[15:8] reads 0 and writes to it are ignored.
//   - No prescaler flops are instantiated.
// STRUCTURE
//  - Shared defines header (core defines): `TIME_INT, `INT_NONE, `ZeroWord, `WriteEnable, plus new
//    localparams for the register offsets (CTRL/VALUE/CNT/INT_STATUS) and the CTRL bit indices.
//  - Sub-module timer_channel holds one channel's en/int_en/pending/mode/psc/value/cnt and its tick logic.
//    It is instantiated NUM_CH times in a generate loop.
//  - The top level decodes addresses, muxes read data and ORs the interrupts.
// TESTING
//  1. Reset: assert rst mid-count -> all CNT/CTRL read 0, int_signal_o == `INT_NONE.
//  2. One-shot: ch0 VALUE = 5, CTRL = 0x3 -> pending set 5 cycles after enable; en reads 0;
//     int_signal_o == `TIME_INT; CNT == 0.
//  3. Periodic: ch1 VALUE = 3, CTRL = 0xB -> pending set every 3 cycles; W1C CTRL[2] clears it;
//     a W1C coinciding with a terminal tick leaves pending = 1.
//  4. Prescaler (macro on): ch2 psc = 3, VALUE = 2, periodic -> fires every 8 cycles.
//     Macro off: the same write fires every 2 cycles and CTRL[15:8] reads 0.
//  5. Edge cases: VALUE = 0 with en = 1 -> never fires. Writing VALUE = 2 while cnt = 7 -> cnt reads 0
//     and the channel fires 2 ticks later.
//  6. Bus: write 0xF0 with 0x5 clears pending on ch0 and ch2 only. Read addr 0xE0 (unmapped) -> 0.
//     A write to CNT is ignored.

Source files
------------

// File: rtl/timer_multi_pkg.sv
// Core bus/interrupt defines plus the register map shared by timer_multi and timer_channel.
// Optional per-channel prescaler is built only when TIMER_PRESCALER_EN is defined.
`ifndef TIMER_MULTI_CORE_DEFINES
`define TIMER_MULTI_CORE_DEFINES
`define WriteEnable 1'b1
`define ZeroWord    32'h0000_0000
`define INT_NONE    32'h0000_0000
`define TIME_INT    32'h0000_0001
`endif

package timer_multi_pkg;
  localparam logic [3:0] OFF_CTRL        = 4'h0;
  localparam logic [3:0] OFF_VALUE       = 4'h4;
  localparam logic [3:0] OFF_CNT         = 4'h8;
  localparam logic [7:0] ADDR_INT_STATUS = 8'hF0;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_INT_EN = 1;
  localparam int CTRL_PEND   = 2;
  localparam int CTRL_MODE   = 3;
  localparam int CTRL_PSC    = 8;

  // Decoded per-channel write request
  typedef struct packed {
    logic        ctrl_we;
    logic        value_we;
    logic        w1c;
    logic [31:0] wdata;
  } ch_wr_t;
endpackage

// File: rtl/timer_multi_channel.sv
// timer_channel: one timer channel -- control bits, compare value, counter and tick logic.
// The prescaler (TIMER_PRESCALER_EN) divides the tick rate by psc+1.
module timer_channel
  import timer_multi_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  ch_wr_t           wr,
  output logic [31:0]      ctrl,
  output logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] cnt,
  output logic             pending
);
  logic en, int_en, mode, tick, fire, unused_wdata;

  assign unused_wdata = ^wr.wdata;

`ifdef TIMER_PRESCALER_EN
  logic [PSC_W-1:0] psc, psc_cnt;

  // >= keeps the divider sane if psc is lowered below the running count
  assign tick = en && (psc_cnt >= psc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc     <= '0;
      psc_cnt <= '0;
    end else begin
      if (wr.ctrl_we) psc <= wr.wdata[CTRL_PSC +: PSC_W];
      if (!en || tick || wr.value_we) psc_cnt <= '0;
      else                            psc_cnt <= psc_cnt + PSC_W'(1);
    end
  end
`else
  assign tick = en;
`endif

  assign fire = tick && (value != '0) && (cnt == value - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en      <= 1'b0;
      int_en  <= 1'b0;
      mode    <= 1'b0;
      pending <= 1'b0;
      value   <= '0;
      cnt     <= '0;
    end else begin
      // A CTRL write overrides the one-shot self-disable
      if (wr.ctrl_we) begin
        en     <= wr.wdata[CTRL_EN];
        int_en <= wr.wdata[CTRL_INT_EN];
        mode   <= wr.wdata[CTRL_MODE];
      end else if (fire && !mode) begin
        en <= 1'b0;
      end
      // Hardware set beats software clear so no interrupt is lost
      if (fire)        pending <= 1'b1;
      else if (wr.w1c) pending <= 1'b0;
      if (wr.value_we) value <= wr.wdata[CNT_W-1:0];
      if (wr.value_we || fire || (wr.ctrl_we && en && !wr.wdata[CTRL_EN]))
        cnt <= '0;
      else if (tick && value != '0)
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    ctrl              = '0;
    ctrl[CTRL_EN]     = en;
    ctrl[CTRL_INT_EN] = int_en;
    ctrl[CTRL_PEND]   = pending;
    ctrl[CTRL_MODE]   = mode;
`ifdef TIMER_PRESCALER_EN
    ctrl[CTRL_PSC +: PSC_W] = psc;
`endif
  end
endmodule

// File: rtl/timer_multi.sv
// timer_multi: N-channel memory-mapped timer; decodes the bus, muxes read data, merges interrupts.
// Build with TIMER_PRESCALER_EN defined to add a per-channel prescaler in CTRL[15:8].
module timer_multi
  import timer_multi_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PSC_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic [NUM_CH-1:0] int_ch_o,
  output logic [31:0]       int_signal_o
);
  logic [3:0] ch_sel, offset;
  logic       is_status, wr_en, unused_addr;

  logic [NUM_CH-1:0][31:0]      ctrl;
  logic [NUM_CH-1:0][CNT_W-1:0] value, cnt;
  logic [NUM_CH-1:0]            pending;

  assign ch_sel      = addr_i[7:4];
  assign offset      = addr_i[3:0];
  assign is_status   = (addr_i[7:0] == ADDR_INT_STATUS);
  assign wr_en       = (we_i == `WriteEnable);
  // Upper address bits are decoded by the bus fabric
  assign unused_addr = ^addr_i[31:8];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_wr_t wr;
    logic   sel;

    assign sel = wr_en && (ch_sel == 4'(c));

    always_comb begin
      wr          = '0;
      wr.ctrl_we  = sel && (offset == OFF_CTRL);
      wr.value_we = sel && (offset == OFF_VALUE);
      wr.w1c      = (wr.ctrl_we && wdata_i[CTRL_PEND]) || (wr_en && is_status && wdata_i[c]);
      wr.wdata    = wdata_i;
    end

    timer_channel #(.CNT_W(CNT_W), .PSC_W(PSC_W)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr),
      .ctrl    (ctrl[c]),
      .value   (value[c]),
      .cnt     (cnt[c]),
      .pending (pending[c])
    );
  end

  always_comb begin
    rdata_o = `ZeroWord;
    if (is_status) begin
      rdata_o[NUM_CH-1:0] = pending;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel == 4'(c)) begin
          case (offset)
            OFF_CTRL:  rdata_o = ctrl[c];
            OFF_VALUE: rdata_o = 32'(value[c]);
            OFF_CNT:   rdata_o = 32'(cnt[c]);
            default:   rdata_o = `ZeroWord;
          endcase
        end
      end
    end
  end

  always_comb begin
    int_ch_o = '0;
    for (int c = 0; c < NUM_CH; c++)
      int_ch_o[c] = pending[c] && ctrl[c][CTRL_INT_EN];
  end

  assign int_signal_o = (|int_ch_o) ? `TIME_INT : `INT_NONE;
endmodule
